// File: rtl/aligned_wr_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : aligned_wr_issuer                                          |
// | Purpose : FIFO-buffered write issuer for the aligned RAM port; checks |
// |           the RAM error response one cycle after each issued write.  |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module aligned_wr_issuer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic             stall,
  output logic             wr_en,
  output logic [31:0]      addr,
  output logic [31:0]      wdata,
  input  logic             error,
  input  logic             clr_err,
  output logic [CNT_W-1:0] err_count,
  output logic [31:0]      err_addr,
  output logic             err_pulse,
  output logic             idle
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  logic [63:0]        mem_q [DEPTH];
  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0] count_q, count_d;
  logic               wr_en_q, wr_en_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               chk_pending_q, chk_pending_d;
  logic [31:0]        chk_addr_q, chk_addr_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [31:0]        err_addr_q, err_addr_d;
  logic               err_pulse_q, err_pulse_d;

  logic               push;
  logic               pop;
  logic               fault;
  logic [63:0]        head;

  assign head  = mem_q[rd_ptr_q];
  // A full FIFO refuses a push even when a pop frees a slot on the same edge.
  assign push  = req_valid && (count_q != c_FULL);
  assign pop   = (count_q != '0) && !stall;
  assign fault = chk_pending_q && error;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    wr_en_d       = pop;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    chk_pending_d = wr_en_q;
    chk_addr_d    = addr_q;
    err_count_d   = err_count_q;
    err_addr_d    = err_addr_q;
    err_pulse_d   = fault;

    if (push) begin
      wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
      addr_d   = head[63:32];
      wdata_d  = head[31:0];
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + c_CNT_W'(1);
      2'b01:   count_d = count_q - c_CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (fault) begin
      err_addr_d = chk_addr_q;
    end
    // A clear that coincides with a fault leaves exactly that fault counted.
    if (clr_err) begin
      err_count_d = fault ? CNT_W'(1) : '0;
    end else if (fault && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_addr, req_wdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      wr_en_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      chk_pending_q <= 1'b0;
      chk_addr_q    <= '0;
      err_count_q   <= '0;
      err_addr_q    <= '0;
      err_pulse_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      wr_en_q       <= wr_en_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      chk_pending_q <= chk_pending_d;
      chk_addr_q    <= chk_addr_d;
      err_count_q   <= err_count_d;
      err_addr_q    <= err_addr_d;
      err_pulse_q   <= err_pulse_d;
    end
  end

  assign req_ready = (count_q != c_FULL);
  assign wr_en     = wr_en_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;
  assign err_pulse = err_pulse_q;
  assign idle      = (count_q == '0) && !wr_en_q && !chk_pending_q;

endmodule
`default_nettype wire

// File: tb/tb_aligned_wr_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_aligned_wr_issuer                                       |
// | Purpose : Directed bench for aligned_wr_issuer with a queue model.   |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_aligned_wr_issuer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        stall = 1'b0;
  logic        clr_err = 1'b0;
  logic        ram_err;

  logic        rdy8, wr_en8, pulse8, idle8;
  logic [31:0] addr8, wdata8, eaddr8;
  logic [7:0]  cnt8;
  logic        rdy2, wr_en2, pulse2, idle2;
  logic [31:0] addr2, wdata2, eaddr2;
  logic [1:0]  cnt2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  aligned_wr_issuer #(.DEPTH(DEPTH), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy8),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
    .wr_en(wr_en8), .addr(addr8), .wdata(wdata8), .error(ram_err),
    .clr_err(clr_err), .err_count(cnt8), .err_addr(eaddr8),
    .err_pulse(pulse8), .idle(idle8)
  );

  aligned_wr_issuer #(.DEPTH(DEPTH), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy2),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
    .wr_en(wr_en2), .addr(addr2), .wdata(wdata2), .error(ram_err),
    .clr_err(clr_err), .err_count(cnt2), .err_addr(eaddr2),
    .err_pulse(pulse2), .idle(idle2)
  );

  // RAM stand-in: flags a misaligned write on the edge that sees wr_en, holds otherwise.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ram_err <= 1'b0;
    else if (wr_en8) ram_err <= (addr8[1:0] != 2'b00);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a request queue plus the registered outputs it implies.
  logic [63:0] mq[$];
  logic        m_wr_en, m_chk, m_ram_err, m_pulse;
  logic [31:0] m_addr, m_wdata, m_chk_addr, m_err_addr;
  int          m_cnt8, m_cnt2;

  task automatic model_reset();
    mq.delete();
    m_wr_en = 0; m_chk = 0; m_ram_err = 0; m_pulse = 0;
    m_addr = 0; m_wdata = 0; m_chk_addr = 0; m_err_addr = 0;
    m_cnt8 = 0; m_cnt2 = 0;
  endtask

  task automatic model_step();
    bit          fault_now, pop_now, push_now;
    logic [63:0] h;
    fault_now = m_chk && m_ram_err;
    if (clr_err) begin
      m_cnt8 = fault_now ? 1 : 0;
      m_cnt2 = fault_now ? 1 : 0;
    end else if (fault_now) begin
      m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
      m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
    end
    m_pulse = fault_now;
    if (fault_now) m_err_addr = m_chk_addr;
    if (m_wr_en) m_ram_err = (m_addr[1:0] != 2'b00);
    m_chk      = m_wr_en;
    m_chk_addr = m_addr;
    pop_now  = (mq.size() > 0) && !stall;
    push_now = req_valid && (mq.size() < DEPTH);
    if (pop_now) begin
      h = mq.pop_front();
      m_wr_en = 1; m_addr = h[63:32]; m_wdata = h[31:0];
    end else begin
      m_wr_en = 0;
    end
    if (push_now) mq.push_back({req_addr, req_wdata});
  endtask

  task automatic compare();
    logic m_idle;
    m_idle = (mq.size() == 0) && !m_wr_en && !m_chk;
    check("req_ready", 32'(rdy8), 32'(mq.size() < DEPTH));
    check("wr_en", 32'(wr_en8), 32'(m_wr_en));
    check("addr", addr8, m_addr);
    check("wdata", wdata8, m_wdata);
    check("err_count", 32'(cnt8), 32'(m_cnt8));
    check("err_addr", eaddr8, m_err_addr);
    check("err_pulse", 32'(pulse8), 32'(m_pulse));
    check("idle", 32'(idle8), 32'(m_idle));
    check("w2_req_ready", 32'(rdy2), 32'(mq.size() < DEPTH));
    check("w2_wr_en", 32'(wr_en2), 32'(m_wr_en));
    check("w2_addr", addr2, m_addr);
    check("w2_wdata", wdata2, m_wdata);
    check("w2_err_count", 32'(cnt2), 32'(m_cnt2));
    check("w2_err_addr", eaddr2, m_err_addr);
    check("w2_err_pulse", 32'(pulse2), 32'(m_pulse));
    check("w2_idle", 32'(idle2), 32'(m_idle));
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      compare();
      if (rst_n) model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Holds the request until an edge accepts it; returns 1ns after that edge.
  task automatic send(input logic [31:0] a, input logic [31:0] d);
    bit done;
    done = 0;
    req_valid = 1'b1; req_addr = a; req_wdata = d;
    for (int i = 0; i < 50 && !done; i++) begin
      done = rdy8;
      tick();
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  initial begin
    idle_ticks(3);
    check("rst_idle", 32'(idle8), 32'd1);
    check("rst_ready", 32'(rdy8), 32'd1);
    check("rst_count", 32'(cnt8), 32'd0);
    rst_n = 1'b1;
    idle_ticks(2);

    // Single aligned write
    send(32'h0000_0010, 32'hDEAD_BEEF);
    tick();
    check("t1_wr_en", 32'(wr_en8), 32'd1);
    check("t1_addr", addr8, 32'h0000_0010);
    check("t1_wdata", wdata8, 32'hDEAD_BEEF);
    tick();
    check("t1_wr_en_low", 32'(wr_en8), 32'd0);
    check("t1_busy", 32'(idle8), 32'd0);
    tick();
    check("t1_idle", 32'(idle8), 32'd1);
    check("t1_count", 32'(cnt8), 32'd0);
    idle_ticks(2);

    // Back-to-back, second one misaligned
    send(32'h0000_0004, 32'h1111_1111);
    send(32'h0000_0006, 32'h2222_2222);
    tick();
    check("t2_addr", addr8, 32'h0000_0006);
    tick();
    check("t2_no_pulse_yet", 32'(pulse8), 32'd0);
    tick();
    check("t2_pulse", 32'(pulse8), 32'd1);
    check("t2_err_addr", eaddr8, 32'h0000_0006);
    check("t2_count", 32'(cnt8), 32'd1);
    tick();
    check("t2_pulse_end", 32'(pulse8), 32'd0);
    idle_ticks(3);

    // Stall fills the FIFO; fifth request waits
    stall = 1'b1;
    for (int i = 0; i < 4; i++) send(32'h0000_1000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    req_valid = 1'b1; req_addr = 32'h0000_1010; req_wdata = 32'hA000_0004;
    check("t3_full", 32'(rdy8), 32'd0);
    idle_ticks(3);
    check("t3_still_full", 32'(rdy8), 32'd0);
    check("t3_no_issue", 32'(wr_en8), 32'd0);
    stall = 1'b0;
    tick();
    check("t3_first_wr", 32'(wr_en8), 32'd1);
    check("t3_first_addr", addr8, 32'h0000_1000);
    send(32'h0000_1010, 32'hA000_0004);
    idle_ticks(8);

    // Fault followed by RAM holding error while idle
    send(32'h0000_0101, 32'h3333_3333);
    idle_ticks(12);
    check("t4_count", 32'(cnt8), 32'd2);
    check("t4_err_addr", eaddr8, 32'h0000_0101);

    // Saturation on the narrow counter
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t5_cleared", 32'(cnt8), 32'd0);
    send(32'h0000_0201, 32'h0);
    send(32'h0000_0202, 32'h1);
    send(32'h0000_0203, 32'h2);
    send(32'h0000_0205, 32'h3);
    send(32'h0000_0206, 32'h4);
    idle_ticks(8);
    check("t5_sat2", 32'(cnt2), 32'd3);
    check("t5_cnt8", 32'(cnt8), 32'd5);

    // clr_err on the same edge as a sampled fault
    send(32'h0000_0301, 32'h5);
    tick();
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t6_cnt2", 32'(cnt2), 32'd1);
    check("t6_cnt8", 32'(cnt8), 32'd1);
    check("t6_pulse", 32'(pulse8), 32'd1);
    check("t6_err_addr", eaddr8, 32'h0000_0301);
    idle_ticks(3);

    // Asynchronous reset with queued entries and a pending check
    stall = 1'b1;
    for (int i = 0; i < 4; i++) send(32'h0000_2001 + 32'(4 * i), 32'hB000_0000 + 32'(i));
    stall = 1'b0;
    tick();
    stall = 1'b1;
    tick();
    check("t7_busy", 32'(idle8), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_wr_en", 32'(wr_en8), 32'd0);
    check("t7_addr", addr8, 32'd0);
    check("t7_wdata", wdata8, 32'd0);
    check("t7_idle", 32'(idle8), 32'd1);
    check("t7_ready", 32'(rdy8), 32'd1);
    check("t7_err_count", 32'(cnt8), 32'd0);
    check("t7_err_addr", eaddr8, 32'd0);
    tick();
    rst_n = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t7_no_wr", 32'(wr_en8), 32'd0);
    end
    check("t7_no_err", 32'(cnt8), 32'd0);
    send(32'h0000_3000, 32'hC0DE_0001);
    tick();
    check("t7_new_wr", 32'(wr_en8), 32'd1);
    check("t7_new_addr", addr8, 32'h0000_3000);
    idle_ticks(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
